// File: rtl/cic_pkg.sv
// cic_pkg: sizing helpers shared by the CIC decimator family
//   clog2      - ceiling log2, used for port and counter widths
//   acc_width  - integrator/comb register width that cannot overflow at the largest decimation
//   norm_shift - left-shift (positive) or rounding right-shift (negative) that normalises a result
package cic_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int acc_width(input int in_w, input int order, input int kmax);
        return in_w + order * kmax + 1;
    endfunction

    function automatic int norm_shift(input int out_w, input int in_w, input int order, input int k);
        return out_w - in_w - order * k;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage: one registered comb section y = x - x_prev with valid tracking
//   clk, rst_n - clock and asynchronous active-low reset
//   clr_i      - synchronous flush of the delay, output and valid
//   x_i, vld_i - input sample and its valid
//   y_o, vld_o - registered comb output and its valid, one clock later
module cic_comb_stage #(
    parameter int W = 30
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic signed [W-1:0] x_i,
    input  logic                vld_i,
    output logic signed [W-1:0] y_o,
    output logic                vld_o
);
    logic signed [W-1:0] dly_q, y_q;
    logic                vld_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            dly_q <= '0;
            y_q   <= '0;
            vld_q <= 1'b0;
        end else if (clr_i) begin
            dly_q <= '0;
            y_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) begin
                y_q   <= x_i - dly_q;
                dly_q <= x_i;
            end
        end

    assign y_o   = y_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/cic_decimator_param.sv
// cic_decimator_param: ORDER-stage CIC decimator, R = 2^k, with normalisation, rounding and saturation
//   clk, rst_n          - clock and asynchronous active-low reset
//   din, din_valid      - input sample and accept strobe
//   cfg_load, cfg_k     - pulse loading decimation exponent k and flushing the filter
//   dout, dout_valid    - normalised saturated output and its one-cycle strobe
//   settling            - high while the first ORDER decimated results are suppressed
//   sat_flag            - sticky saturation indicator, cleared by cfg_load
module cic_decimator_param
    import cic_pkg::*;
#(
    parameter int ORDER    = 7,
    parameter int IN_W     = 1,
    parameter int DSM_MODE = 1,
    parameter int KMAX     = 4,
    parameter int DEF_K    = 3,
    parameter int OUT_W    = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [IN_W-1:0]              din,
    input  logic                         din_valid,
    input  logic                         cfg_load,
    input  logic [clog2(KMAX+1)-1:0]     cfg_k,
    output logic signed [OUT_W-1:0]      dout,
    output logic                         dout_valid,
    output logic                         settling,
    output logic                         sat_flag
);
    localparam int ACC_W = acc_width(IN_W, ORDER, KMAX);
    localparam int KW    = clog2(KMAX + 1);
    localparam int PW    = KMAX > 0 ? KMAX : 1;
    localparam int SW    = clog2(ORDER + 1);
    localparam int NW    = ACC_W + OUT_W + 1;

    logic [KW-1:0]           k_q;
    logic [PW-1:0]           phase_q;
    logic                    strb_q, last;
    logic signed [ACC_W-1:0] x, acc;
    logic signed [ACC_W-1:0] integ_d [ORDER];
    logic signed [ACC_W-1:0] integ_q [ORDER];
    logic signed [ACC_W-1:0] c_dat   [ORDER+1];
    logic                    c_vld   [ORDER+1];
    logic [SW-1:0]           sup_q;
    logic                    settled, sat_q, dout_valid_q, sat_hi, sat_lo;
    logic signed [OUT_W-1:0] dout_q, res;
    logic signed [NW-1:0]    ext, norm;
    int                      s;

    // Delta-sigma bitstreams map 0/1 to -1/+1; otherwise din is already two's complement.
    assign x = DSM_MODE != 0 ? (din[0] ? ACC_W'(1) : '1) : ACC_W'(signed'(din));

    // Integrator cascade updates in one clock: each stage sees the new value of the one before it,
    // built as running prefix sums of the registered values to keep the path loop-free.
    always_comb begin
        acc = x;
        for (int i = 0; i < ORDER; i++) begin
            acc        = acc + integ_q[i];
            integ_d[i] = acc;
        end
    end

    assign last = int'(phase_q) == (1 << k_q) - 1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            k_q     <= KW'(DEF_K);
            phase_q <= '0;
            strb_q  <= 1'b0;
            integ_q <= '{default: '0};
        end else if (cfg_load) begin
            k_q     <= cfg_k > KW'(KMAX) ? KW'(KMAX) : cfg_k;
            phase_q <= '0;
            strb_q  <= 1'b0;
            integ_q <= '{default: '0};
        end else if (din_valid) begin
            integ_q <= integ_d;
            phase_q <= last ? '0 : phase_q + 1'b1;
            strb_q  <= last;
        end else begin
            strb_q  <= 1'b0;
        end

    // The last integrator is sampled by the first comb on the clock after the strobe.
    assign c_dat[0] = integ_q[ORDER-1];
    assign c_vld[0] = strb_q;

    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        cic_comb_stage #(.W(ACC_W)) u_comb (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (cfg_load),
            .x_i   (c_dat[g]),
            .vld_i (c_vld[g]),
            .y_o   (c_dat[g+1]),
            .vld_o (c_vld[g+1])
        );
    end

    // Normalise in a width wide enough for the largest left shift, then clamp to OUT_W.
    always_comb begin
        s      = norm_shift(OUT_W, IN_W, ORDER, int'(k_q));
        ext    = NW'(c_dat[ORDER]);
        norm   = s >= 0 ? ext <<< s : (ext + (NW'(1) <<< (-s - 1))) >>> (-s);
        sat_hi = !norm[NW-1] && (|norm[NW-2:OUT_W-1]);
        sat_lo = norm[NW-1] && !(&norm[NW-2:OUT_W-1]);
        res    = sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} : sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} : norm[OUT_W-1:0];
    end

    assign settled = sup_q == SW'(ORDER);

    // The first ORDER decimated results carry partial integrator history and are swallowed here.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sup_q        <= '0;
            sat_q        <= 1'b0;
        end else if (cfg_load) begin
            dout_valid_q <= 1'b0;
            sup_q        <= '0;
            sat_q        <= 1'b0;
        end else begin
            dout_valid_q <= c_vld[ORDER] && settled;
            if (c_vld[ORDER] && !settled)
                sup_q <= sup_q + 1'b1;
            if (c_vld[ORDER] && settled) begin
                dout_q <= res;
                sat_q  <= sat_q | sat_hi | sat_lo;
            end
        end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign settling   = !settled;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_cic_decimator_param.sv
// tb_cic_decimator_param: scoreboard bench; expected outputs come from a direct FIR convolution model
module tb_cic_decimator_param;
    localparam int ORDER = 7;
    localparam int IN_W  = 1;
    localparam int KMAX  = 4;
    localparam int DEF_K = 3;
    localparam int OUT_W = 24;
    localparam int LAT   = ORDER + 2;
    localparam longint MAXV = (64'sd1 <<< (OUT_W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (OUT_W - 1));

    typedef struct {
        logic [OUT_W-1:0] d;
        bit               sat;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [IN_W-1:0]  din = '0;
    logic             din_valid = 1'b0;
    logic             cfg_load = 1'b0;
    logic [2:0]       cfg_k = '0;
    logic [OUT_W-1:0] dout;
    logic             dout_valid, settling, sat_flag;

    int               vecs = 0;
    int               fails = 0;
    int               edge_cnt = 0;
    exp_t             sb[$];
    exp_t             e;
    int               hist[$];
    longint           h[$];
    int               mk, mphase, msup;
    bit               msat;
    logic [OUT_W-1:0] last_dout = '0;

    cic_decimator_param #(
        .ORDER(ORDER), .IN_W(IN_W), .DSM_MODE(1), .KMAX(KMAX), .DEF_K(DEF_K), .OUT_W(OUT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .cfg_load   (cfg_load),
        .cfg_k      (cfg_k),
        .dout       (dout),
        .dout_valid (dout_valid),
        .settling   (settling),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    // Impulse response of the CIC: a length-R box convolved with itself ORDER times.
    task automatic calc_h();
        longint t[$];
        longint a;
        int     r;
        r = 1 << mk;
        h.delete();
        h.push_back(1);
        repeat (ORDER) begin
            t.delete();
            for (int i = 0; i < h.size() + r - 1; i++) begin
                a = 0;
                for (int j = 0; j < r; j++)
                    if (i - j >= 0 && i - j < h.size()) a += h[i-j];
                t.push_back(a);
            end
            h = t;
        end
    endtask

    task automatic model_clear(input int kk);
        mk     = kk > KMAX ? KMAX : kk;
        mphase = 0;
        msup   = 0;
        msat   = 0;
        hist.delete();
        sb.delete();
        calc_h();
    endtask

    task automatic model_sample(input bit d);
        longint y, v;
        int     n, s;
        exp_t   x;
        hist.push_back(d ? 1 : -1);
        if (mphase != (1 << mk) - 1) begin
            mphase++;
            return;
        end
        mphase = 0;
        if (msup < ORDER) begin
            msup++;
            return;
        end
        n = hist.size();
        y = 0;
        for (int j = 0; j < h.size() && j < n; j++) y += h[j] * hist[n-1-j];
        s = OUT_W - IN_W - ORDER * mk;
        if (s >= 0) v = y <<< s;
        else        v = (y + (64'sd1 <<< (-s - 1))) >>> (-s);
        if (v > MAXV) begin
            v = MAXV;
            msat = 1;
        end else if (v < MINV) begin
            v = MINV;
            msat = 1;
        end
        x.d   = v[OUT_W-1:0];
        x.sat = msat;
        x.cyc = edge_cnt;
        sb.push_back(x);
    endtask

    task automatic put(input bit v, input bit d);
        @(negedge clk);
        din_valid = v;
        din       = d;
        cfg_load  = 1'b0;
        if (v) model_sample(d);
    endtask

    task automatic load(input int kk, input bit v);
        @(negedge clk);
        cfg_load  = 1'b1;
        cfg_k     = 3'(kk);
        din_valid = v;
        din       = 1'b1;
        #1 model_clear(kk);
        @(negedge clk);
        cfg_load  = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4 * LAT && sb.size() > 0; i++) put(0, 0);
        repeat (3) put(0, 0);
    endtask

    task automatic run_dc_pos(input int nstrobe);
        for (int i = 0; i < nstrobe * 8; i++) begin
            put(1, 1);
            repeat (3) put(0, 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid) begin
                vecs++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_dout: dout_valid with dout=%h, no output expected", dout);
                end else begin
                    e = sb.pop_front();
                    if (dout !== e.d) begin
                        fails++;
                        $display("FAIL dout: got %h, expected %h", dout, e.d);
                    end
                    vecs++;
                    if (edge_cnt - e.cyc != LAT) begin
                        fails++;
                        $display("FAIL latency: got %0d clocks, expected %0d", edge_cnt - e.cyc, LAT);
                    end
                    vecs++;
                    if (sat_flag !== e.sat) begin
                        fails++;
                        $display("FAIL sat_flag_out: got %b, expected %b", sat_flag, e.sat);
                    end
                    vecs++;
                    if (settling !== 1'b0) begin
                        fails++;
                        $display("FAIL settling_out: got %b, expected 0", settling);
                    end
                end
            end else begin
                vecs++;
                if (dout !== last_dout) begin
                    fails++;
                    $display("FAIL dout_hold: got %h, expected %h", dout, last_dout);
                end
            end
        end
        last_dout = dout;
    end

    task automatic test_reset();
        rst_n     = 1'b0;
        din_valid = 1'b1;
        din       = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vecs += 4;
        if (dout !== '0) begin fails++; $display("FAIL reset_dout: got %h, expected 000000", dout); end
        if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_dout_valid: got %b, expected 0", dout_valid); end
        if (settling !== 1'b1) begin fails++; $display("FAIL reset_settling: got %b, expected 1", settling); end
        if (sat_flag !== 1'b0) begin fails++; $display("FAIL reset_sat_flag: got %b, expected 0", sat_flag); end
        @(negedge clk);
        rst_n     = 1'b1;
        din_valid = 1'b0;
        model_clear(DEF_K);
    endtask

    task automatic test_dc_pos();
        vecs++;
        if (settling !== 1'b1) begin fails++; $display("FAIL dc_pos_settling_start: got %b, expected 1", settling); end
        run_dc_pos(12);
        wait_drain();
        vecs += 2;
        if (sb.size() != 0) begin fails++; $display("FAIL dc_pos_missing: %0d outputs not seen, expected 0", sb.size()); end
        if (sat_flag !== 1'b1) begin fails++; $display("FAIL dc_pos_sat: got %b, expected 1", sat_flag); end
    endtask

    task automatic test_dc_neg();
        load(3, 0);
        vecs++;
        if (sat_flag !== 1'b0) begin fails++; $display("FAIL dc_neg_sat_cleared: got %b, expected 0", sat_flag); end
        repeat (96) put(1, 0);
        wait_drain();
        vecs += 2;
        if (sb.size() != 0) begin fails++; $display("FAIL dc_neg_missing: %0d outputs not seen, expected 0", sb.size()); end
        if (sat_flag !== 1'b0) begin fails++; $display("FAIL dc_neg_sat: got %b, expected 0", sat_flag); end
    endtask

    task automatic test_alternating();
        load(3, 0);
        for (int i = 0; i < 96; i++) put(1, i[0]);
        wait_drain();
        vecs++;
        if (sb.size() != 0) begin fails++; $display("FAIL alt_missing: %0d outputs not seen, expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back_k0();
        load(0, 0);
        repeat (30) put(1, 1);
        wait_drain();
        vecs++;
        if (sb.size() != 0) begin fails++; $display("FAIL k0_missing: %0d outputs not seen, expected 0", sb.size()); end
    endtask

    task automatic test_load_mid();
        load(3, 0);
        repeat (79) put(1, 1);
        vecs++;
        if (sat_flag !== 1'b1) begin fails++; $display("FAIL mid_sat_before: got %b, expected 1", sat_flag); end
        load(1, 1);
        vecs += 2;
        if (settling !== 1'b1) begin fails++; $display("FAIL mid_settling: got %b, expected 1", settling); end
        if (sat_flag !== 1'b0) begin fails++; $display("FAIL mid_sat_cleared: got %b, expected 0", sat_flag); end
        repeat (60) put(1, 1'($urandom_range(0, 1)));
        wait_drain();
        vecs++;
        if (sb.size() != 0) begin fails++; $display("FAIL mid_missing: %0d outputs not seen, expected 0", sb.size()); end
    endtask

    task automatic test_k_clamp_round();
        load(7, 0);
        repeat (300) put($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
        wait_drain();
        vecs++;
        if (sb.size() != 0) begin fails++; $display("FAIL clamp_missing: %0d outputs not seen, expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        load(3, 0);
        repeat (72) put(1, 1);
        repeat (4) put(0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        vecs += 3;
        if (dout !== '0) begin fails++; $display("FAIL rstmid_dout: got %h, expected 000000", dout); end
        if (dout_valid !== 1'b0) begin fails++; $display("FAIL rstmid_dout_valid: got %b, expected 0", dout_valid); end
        if (settling !== 1'b1) begin fails++; $display("FAIL rstmid_settling: got %b, expected 1", settling); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear(DEF_K);
        run_dc_pos(10);
        wait_drain();
        vecs += 2;
        if (sb.size() != 0) begin fails++; $display("FAIL rstmid_missing: %0d outputs not seen, expected 0", sb.size()); end
        if (sat_flag !== 1'b1) begin fails++; $display("FAIL rstmid_sat: got %b, expected 1", sat_flag); end
    endtask

    initial begin
        test_reset();
        test_dc_pos();
        test_dc_neg();
        test_alternating();
        test_back_to_back_k0();
        test_load_mid();
        test_k_clamp_round();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
